// File: rtl/mod_add_sched.sv
// mod_add_sched: round-robin front end sharing one pipelined modular adder among NREQ requesters
module mod_add_sched #(
    parameter int          NREQ = 4,
    parameter logic [31:0] MOD  = 32'd4294967291,
    parameter int          BW   = $clog2(MOD),
    parameter int          LAT  = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    REQ_VALID,
    input  logic [NREQ*BW-1:0] REQ_A,
    input  logic [NREQ*BW-1:0] REQ_B,
    output logic [NREQ-1:0]    REQ_READY,
    output logic [BW-1:0]      ADD_A,
    output logic [BW-1:0]      ADD_B,
    input  logic [BW-1:0]      ADD_Z,
    output logic [NREQ-1:0]    RES_VALID,
    output logic [BW-1:0]      RES_DATA,
    output logic               RES_ERR,
    output logic               BUSY
);
    localparam int PW = $clog2(NREQ);
    localparam logic [BW:0] MODX = (BW+1)'(MOD);
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          hit;
    logic          hs;
    logic          err;
    logic [BW-1:0] a_sel;
    logic [BW-1:0] b_sel;
    logic [LAT+1:0] tv;
    logic [LAT+1:0] te;
    logic [PW-1:0]  ti [LAT+2];
    // first valid requester at or after the pointer, wrapping; lowest offset wins
    always_comb begin
        int k;
        k = 0;
        win = '0;
        hit = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            k = int'(ptr) + j;
            k = (k >= NREQ) ? k - NREQ : k;
            if (REQ_VALID[k]) begin
                win = PW'(k);
                hit = 1'b1;
            end
        end
    end
    assign hs        = hit & ~RST;
    assign REQ_READY = hs ? (NREQ'(1) << win) : '0;
    assign a_sel     = REQ_A[win*BW +: BW];
    assign b_sel     = REQ_B[win*BW +: BW];
    assign err       = ({1'b0, a_sel} >= MODX) | ({1'b0, b_sel} >= MODX);
    assign BUSY      = |tv;
    // issue, tag-valid chain and result capture; the chain is LAT+2 deep because the
    // operand register adds one cycle before the adder's own LAT stages
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr       <= '0;
            ADD_A     <= '0;
            ADD_B     <= '0;
            tv        <= '0;
            RES_VALID <= '0;
            RES_DATA  <= '0;
            RES_ERR   <= 1'b0;
        end else begin
            if (hs) begin
                ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                ADD_A <= err ? '0 : a_sel;
                ADD_B <= err ? '0 : b_sel;
            end
            tv        <= {tv[LAT:0], hs};
            RES_VALID <= tv[LAT+1] ? (NREQ'(1) << ti[LAT+1]) : '0;
            if (tv[LAT+1]) begin
                RES_DATA <= te[LAT+1] ? '0 : ADD_Z;
                RES_ERR  <= te[LAT+1];
            end
        end
    end
    // tag payload travels alongside the valid chain; meaningful only where tv is set
    always_ff @(posedge CLK) begin
        te    <= {te[LAT:0], err};
        ti[0] <= win;
        for (int s = 1; s < LAT + 2; s++) ti[s] <= ti[s-1];
    end
endmodule
